// File: rtl/udp_rx_port_filter.sv
// Byte-serial Ethernet/IPv4/UDP receive filter: validates the headers, matches the UDP
// destination port against NUM_CH channels and streams the trimmed payload with sideband.
module udp_rx_port_filter #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int HDR_OFFSET = 0,
    parameter int MCAST_EN   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [47:0]          local_mac,
    input  logic [31:0]          local_ip,
    input  logic [16*NUM_CH-1:0] port_table,
    input  logic [NUM_CH-1:0]    port_en,
    input  logic [7:0]           rx_data,
    input  logic                 rx_data_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    output logic                 tx_sof,
    output logic                 tx_eof,
    output logic                 tx_abort,
    output logic [CH_W-1:0]      tx_ch,
    output logic [47:0]          src_mac,
    output logic [31:0]          src_ip,
    output logic [15:0]          src_port,
    output logic [CNT_W-1:0]     frame_ok_cnt,
    output logic [CNT_W-1:0]     frame_drop_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DROP} state_t;

    localparam logic [15:0] OFS = 16'(HDR_OFFSET);

    state_t          r_state, w_state_nx;
    logic            r_vld_d, r_first, r_uc, r_bc, r_mc;
    logic [15:0]     r_raw, r_rem;
    logic [7:0]      r_hi, r_data_p0;
    logic [47:0]     r_cap_mac;
    logic [31:0]     r_cap_ip;
    logic [15:0]     r_cap_port;
    logic [CH_W-1:0] r_cap_ch;
    logic            r_vld_p0, r_sof_p0, r_eof_p0, r_abort_p0;

    logic            w_start, w_hdr_byte, w_hit, w_uc, w_bc, w_mc_ok, w_fail;
    logic            w_emit, w_eof, w_abort, w_ok_inc, w_drop_inc;
    logic [15:0]     w_raw, w_k, w_port;
    logic [7:0]      w_ref;
    logic [CH_W-1:0] w_ch;

    // Lowest enabled channel whose table entry equals the port wins.
    function automatic logic [CH_W:0] port_lookup(input logic [15:0] port,
                                                  input logic [16*NUM_CH-1:0] tbl,
                                                  input logic [NUM_CH-1:0] en);
        logic [CH_W:0] res;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en[i] && (tbl[16*i +: 16] == port)) res = {1'b1, CH_W'(i)};
        end
        return res;
    endfunction

    always_comb begin
        w_start    = rx_data_valid && !r_vld_d;
        w_raw      = (r_state == S_IDLE) ? 16'd0 : r_raw;
        w_k        = w_raw - OFS;
        w_hdr_byte = ((r_state == S_IDLE && w_start) || (r_state == S_HDR && rx_data_valid))
                     && (w_raw >= OFS);
        w_port     = {r_hi, rx_data};
        {w_hit, w_ch} = port_lookup(w_port, port_table, port_en);

        w_ref = 8'h00;
        case (w_k)
            16'd0:   w_ref = local_mac[47:40];
            16'd1:   w_ref = local_mac[39:32];
            16'd2:   w_ref = local_mac[31:24];
            16'd3:   w_ref = local_mac[23:16];
            16'd4:   w_ref = local_mac[15:8];
            16'd5:   w_ref = local_mac[7:0];
            16'd30:  w_ref = local_ip[31:24];
            16'd31:  w_ref = local_ip[23:16];
            16'd32:  w_ref = local_ip[15:8];
            16'd33:  w_ref = local_ip[7:0];
            default: w_ref = 8'h00;
        endcase
        // One running unicast flag serves both the MAC and the IP field.
        w_uc    = ((w_k == 16'd0 || w_k == 16'd30) ? 1'b1 : r_uc) && (rx_data == w_ref);
        w_bc    = ((w_k == 16'd0) ? 1'b1 : r_bc) && (rx_data == 8'hFF);
        w_mc_ok = (MCAST_EN != 0) && r_mc;

        w_fail = 1'b0;
        if (w_hdr_byte) begin
            case (w_k)
                16'd5:   w_fail = !(w_uc || w_bc || w_mc_ok);
                16'd12:  w_fail = (rx_data != 8'h08);
                16'd13:  w_fail = (rx_data != 8'h00);
                16'd14:  w_fail = (rx_data != 8'h45);
                16'd23:  w_fail = (rx_data != 8'h11);
                16'd33:  w_fail = !(w_uc || w_mc_ok);
                16'd37:  w_fail = !w_hit;
                16'd39:  w_fail = (w_port <= 16'd8);
                default: w_fail = 1'b0;
            endcase
        end

        w_state_nx = r_state;
        w_emit     = 1'b0;
        w_abort    = 1'b0;
        w_ok_inc   = 1'b0;
        w_drop_inc = 1'b0;
        w_eof      = (r_rem == 16'd1);
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nx = w_fail ? S_DROP : S_HDR;
                    w_drop_inc = w_fail;
                end
            end
            S_HDR: begin
                if (!rx_data_valid) begin
                    w_state_nx = S_IDLE;
                    w_drop_inc = 1'b1;
                end else if (w_fail) begin
                    w_state_nx = S_DROP;
                    w_drop_inc = 1'b1;
                end else if (w_hdr_byte && w_k == 16'd41) begin
                    w_state_nx = S_PAY;
                end
            end
            S_PAY: begin
                if (!rx_data_valid) begin
                    w_state_nx = S_IDLE;
                    w_abort    = 1'b1;
                    w_drop_inc = 1'b1;
                end else begin
                    w_emit = 1'b1;
                    if (w_eof) begin
                        w_state_nx = S_DROP;
                        w_ok_inc   = 1'b1;
                    end
                end
            end
            default: begin
                if (!rx_data_valid) w_state_nx = S_IDLE;
            end
        endcase
    end

    // Header parse: byte counter, match flags, captured sideband, payload down-counter
    always_ff @(posedge clk) begin
        r_raw     <= w_raw + 16'd1;
        r_first   <= (r_state != S_PAY);
        r_data_p0 <= rx_data;
        if (w_hdr_byte) begin
            r_uc <= w_uc;
            r_bc <= w_bc;
            if (w_k == 16'd0)  r_mc <= rx_data[0];
            if (w_k == 16'd30) r_mc <= (rx_data[7:4] == 4'hE);
            if (w_k == 16'd36 || w_k == 16'd38) r_hi <= rx_data;
            if (w_k >= 16'd6 && w_k <= 16'd11)  r_cap_mac  <= {r_cap_mac[39:0], rx_data};
            if (w_k >= 16'd26 && w_k <= 16'd29) r_cap_ip   <= {r_cap_ip[23:0], rx_data};
            if (w_k == 16'd34 || w_k == 16'd35) r_cap_port <= {r_cap_port[7:0], rx_data};
            if (w_k == 16'd37) r_cap_ch <= w_ch;
            if (w_k == 16'd39) r_rem <= w_port - 16'd8;
        end else if (w_emit) begin
            r_rem <= r_rem - 16'd1;
        end
    end

    // Control, stage p0 markers, output stage and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_vld_d        <= 1'b1;
            r_vld_p0       <= 1'b0;
            r_sof_p0       <= 1'b0;
            r_eof_p0       <= 1'b0;
            r_abort_p0     <= 1'b0;
            tx_data        <= 8'h00;
            tx_data_valid  <= 1'b0;
            tx_sof         <= 1'b0;
            tx_eof         <= 1'b0;
            tx_abort       <= 1'b0;
            tx_ch          <= '0;
            src_mac        <= 48'h0;
            src_ip         <= 32'h0;
            src_port       <= 16'h0;
            frame_ok_cnt   <= '0;
            frame_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_vld_d    <= rx_data_valid;
            r_vld_p0   <= w_emit;
            r_sof_p0   <= w_emit && r_first;
            r_eof_p0   <= w_emit && w_eof;
            r_abort_p0 <= w_abort;

            tx_data_valid <= r_vld_p0;
            tx_data       <= r_vld_p0 ? r_data_p0 : 8'h00;
            tx_sof        <= r_sof_p0;
            tx_eof        <= r_eof_p0;
            tx_abort      <= r_abort_p0;
            if (r_sof_p0) begin
                tx_ch    <= r_cap_ch;
                src_mac  <= r_cap_mac;
                src_ip   <= r_cap_ip;
                src_port <= r_cap_port;
            end
            if (w_ok_inc)   frame_ok_cnt   <= frame_ok_cnt + CNT_W'(1);
            if (w_drop_inc) frame_drop_cnt <= frame_drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_udp_rx_port_filter.sv
// Directed table-driven bench for udp_rx_port_filter: frames are built byte by byte and
// the emitted payload, markers, sideband and counters are compared to table values.
module tb_udp_rx_port_filter;

    localparam logic [47:0] LMAC = 48'h000A35010203;
    localparam logic [31:0] LIP  = 32'hC0A8010A;
    localparam logic [47:0] SMAC = 48'h021122334455;
    localparam logic [31:0] SIP  = 32'h0A000007;

    typedef struct {
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [15:0] etype;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [15:0] dport;
        logic [15:0] ulen;
        int          hdr_n;
        int          tail_n;
        logic [3:0]  pen;
        int          exp_n;
        int          exp_eof;
        int          exp_abort;
        int          exp_ch;
        int          ok_d;
        int          drop_d;
        int          nm_ok_d;
        int          nm_drop_d;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [63:0] port_table;
    logic [3:0]  port_en;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic [7:0]  tx_data;
    logic        tx_data_valid, tx_sof, tx_eof, tx_abort;
    logic [1:0]  tx_ch;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] frame_ok_cnt, frame_drop_cnt;
    logic [7:0]  nm_data;
    logic        nm_valid, nm_sof, nm_eof, nm_abort;
    logic [1:0]  nm_ch;
    logic [47:0] nm_mac;
    logic [31:0] nm_ip;
    logic [15:0] nm_port;
    logic [15:0] nm_ok_cnt, nm_drop_cnt;

    udp_rx_port_filter u_dut (
        .clk(clk), .rst(rst), .local_mac(LMAC), .local_ip(LIP),
        .port_table(port_table), .port_en(port_en),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_sof(tx_sof), .tx_eof(tx_eof),
        .tx_abort(tx_abort), .tx_ch(tx_ch), .src_mac(src_mac), .src_ip(src_ip),
        .src_port(src_port), .frame_ok_cnt(frame_ok_cnt), .frame_drop_cnt(frame_drop_cnt)
    );

    udp_rx_port_filter #(.MCAST_EN(0)) u_dut_nm (
        .clk(clk), .rst(rst), .local_mac(LMAC), .local_ip(LIP),
        .port_table(port_table), .port_en(port_en),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .tx_data(nm_data), .tx_data_valid(nm_valid), .tx_sof(nm_sof), .tx_eof(nm_eof),
        .tx_abort(nm_abort), .tx_ch(nm_ch), .src_mac(nm_mac), .src_ip(nm_ip),
        .src_port(nm_port), .frame_ok_cnt(nm_ok_cnt), .frame_drop_cnt(nm_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge
    logic [7:0]  rx_q[$];
    int          sof_cnt = 0, eof_cnt = 0, abort_cnt = 0, abort_adj = 0, idle_bad = 0;
    int          sof_pos = 0, eof_pos = 0;
    logic        prev_vld = 1'b0;
    logic [1:0]  sof_ch;
    logic [47:0] sof_mac;
    logic [31:0] sof_ip;
    logic [15:0] sof_port;

    always @(negedge clk) begin
        if (tx_data_valid) begin
            rx_q.push_back(tx_data);
            if (tx_sof) begin
                sof_cnt++;
                sof_pos  = rx_q.size();
                sof_ch   = tx_ch;
                sof_mac  = src_mac;
                sof_ip   = src_ip;
                sof_port = src_port;
            end
            if (tx_eof) begin
                eof_cnt++;
                eof_pos = rx_q.size();
            end
        end else if (tx_data != 8'h00) begin
            idle_bad++;
        end
        if (tx_abort) begin
            abort_cnt++;
            if (prev_vld && !tx_data_valid) abort_adj++;
        end
        prev_vld = tx_data_valid;
    end

    int n_chk = 0, n_err = 0;
    int exp_ok = 0, exp_drop = 0, exp_nm_ok = 0, exp_nm_drop = 0;
    int b_n, b_sof, b_eof, b_abort, b_adj;
    vec_t vt[15];
    vec_t vr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int idx, input int j);
        return 8'(8'h30 + 7 * j + idx);
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input vec_t v, input int idx, input int rst_at);
        logic [7:0]  h[42];
        logic [47:0] sm;
        logic [31:0] si;
        logic [15:0] sp, tl;
        sm = SMAC;
        si = SIP;
        sp = 16'h5000 + 16'(idx);
        tl = v.ulen + 16'd20;
        for (int i = 0; i < 6; i++) begin
            h[i]     = v.dmac[8*(5-i) +: 8];
            h[6 + i] = sm[8*(5-i) +: 8];
        end
        h[12] = v.etype[15:8]; h[13] = v.etype[7:0]; h[14] = v.ver;    h[15] = 8'h00;
        h[16] = tl[15:8];      h[17] = tl[7:0];      h[18] = 8'h00;    h[19] = 8'h00;
        h[20] = 8'h40;         h[21] = 8'h00;        h[22] = 8'h40;    h[23] = v.proto;
        h[24] = 8'h00;         h[25] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            h[26 + i] = si[8*(3-i) +: 8];
            h[30 + i] = v.dip[8*(3-i) +: 8];
        end
        h[34] = sp[15:8];      h[35] = sp[7:0];      h[36] = v.dport[15:8]; h[37] = v.dport[7:0];
        h[38] = v.ulen[15:8];  h[39] = v.ulen[7:0];  h[40] = 8'h00;        h[41] = 8'h00;
        port_en = v.pen;
        b_n = rx_q.size(); b_sof = sof_cnt; b_eof = eof_cnt; b_abort = abort_cnt; b_adj = abort_adj;
        for (int i = 0; i < v.hdr_n; i++) drive_byte(h[i]);
        for (int j = 0; j < v.tail_n; j++) begin
            rst = (j == rst_at);
            drive_byte(pay_byte(idx, j));
        end
        rst           = 1'b0;
        rx_data_valid = 1'b0;
        rx_data       = 8'h00;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input vec_t v, input int idx);
        int bad;
        exp_ok      += v.ok_d;
        exp_drop    += v.drop_d;
        exp_nm_ok   += v.nm_ok_d;
        exp_nm_drop += v.nm_drop_d;
        chk($sformatf("v%0d_bytes", idx), rx_q.size() - b_n, v.exp_n);
        if (v.exp_n > 0) begin
            bad = 0;
            for (int j = 0; j < v.exp_n; j++) begin
                if (b_n + j < rx_q.size() && rx_q[b_n + j] != pay_byte(idx, j)) bad++;
            end
            chk($sformatf("v%0d_payload_bad", idx), bad, 0);
            chk($sformatf("v%0d_sof_pos", idx), sof_pos - b_n, 1);
            chk($sformatf("v%0d_ch", idx), sof_ch, v.exp_ch);
            chk($sformatf("v%0d_src_mac", idx), sof_mac, SMAC);
            chk($sformatf("v%0d_src_ip", idx), sof_ip, SIP);
            chk($sformatf("v%0d_src_port", idx), sof_port, 16'h5000 + 16'(idx));
        end
        chk($sformatf("v%0d_sof_cnt", idx), sof_cnt - b_sof, (v.exp_n > 0) ? 1 : 0);
        chk($sformatf("v%0d_eof_cnt", idx), eof_cnt - b_eof, v.exp_eof);
        if (v.exp_eof != 0) chk($sformatf("v%0d_eof_pos", idx), eof_pos - b_n, v.exp_n);
        chk($sformatf("v%0d_abort", idx), abort_cnt - b_abort, v.exp_abort);
        chk($sformatf("v%0d_abort_timing", idx), abort_adj - b_adj, v.exp_abort);
        chk($sformatf("v%0d_ok_cnt", idx), frame_ok_cnt, exp_ok);
        chk($sformatf("v%0d_drop_cnt", idx), frame_drop_cnt, exp_drop);
        chk($sformatf("v%0d_nm_ok_cnt", idx), nm_ok_cnt, exp_nm_ok);
        chk($sformatf("v%0d_nm_drop_cnt", idx), nm_drop_cnt, exp_nm_drop);
        chk($sformatf("v%0d_idle_data", idx), idle_bad, 0);
    endtask

    initial begin
        //           dmac              dip           etype   ver    proto  dport     ulen    hdr tail pen      n eof ab ch ok dr nok ndr
        vt[0]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0014, 42, 16, 4'b0100, 12, 1, 0, 2, 1, 0, 1, 0};
        vt[1]  = '{LMAC,               LIP,          16'h0806, 8'h45, 8'h11, 16'h1F90, 16'h0014, 42, 16, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[2]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h06, 16'h1F90, 16'h0014, 42, 16, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[3]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F91, 16'h0014, 42, 16, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[4]  = '{48'h01005E010101,   32'hEF010101, 16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h000C, 42,  8, 4'b0100,  4, 1, 0, 2, 1, 0, 0, 1};
        vt[5]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0009, 42,  5, 4'b1001,  1, 1, 0, 0, 1, 0, 1, 0};
        vt[6]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h000A, 42,  2, 4'b1000,  2, 1, 0, 3, 1, 0, 1, 0};
        vt[7]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0064, 42, 10, 4'b0100, 10, 0, 1, 2, 0, 1, 0, 1};
        vt[8]  = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0008, 42,  4, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[9]  = '{48'hFFFFFFFFFFFF,   LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h000B, 42,  7, 4'b0100,  3, 1, 0, 2, 1, 0, 1, 0};
        vt[10] = '{LMAC,               LIP,          16'h0800, 8'h46, 8'h11, 16'h1F90, 16'h0014, 42, 16, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[11] = '{LMAC,               32'hC0A8010B, 16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0014, 42, 16, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[12] = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0014, 20,  0, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[13] = '{LMAC,               LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0014, 42, 16, 4'b0000,  0, 0, 0, 0, 0, 1, 0, 1};
        vt[14] = '{48'h000A35010204,   LIP,          16'h0800, 8'h45, 8'h11, 16'h1F90, 16'h0014, 42, 16, 4'b0100,  0, 0, 0, 0, 0, 1, 0, 1};

        port_table    = {16'h1F90, 16'h1F90, 16'h1234, 16'h1F90};
        port_en       = 4'b0000;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", tx_data_valid, 0);
        chk("reset_data", tx_data, 0);
        chk("reset_ch", tx_ch, 0);
        chk("reset_src_mac", src_mac, 0);
        chk("reset_ok_cnt", frame_ok_cnt, 0);
        chk("reset_drop_cnt", frame_drop_cnt, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 15; v++) begin
            send_frame(vt[v], v, -1);
            check_frame(vt[v], v);
        end

        // Reset on the third payload byte: only the first byte escapes, counters restart
        vr           = vt[0];
        vr.exp_n     = 1;
        vr.exp_eof   = 0;
        vr.ok_d      = 0;
        vr.drop_d    = 0;
        vr.nm_ok_d   = 0;
        vr.nm_drop_d = 0;
        exp_ok       = 0;
        exp_drop     = 0;
        exp_nm_ok    = 0;
        exp_nm_drop  = 0;
        send_frame(vr, 20, 2);
        check_frame(vr, 20);
        send_frame(vt[0], 21, -1);
        check_frame(vt[0], 21);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
